// File: rtl/axi_dw_pkg.sv
// axi_dw_pkg: shared FSM state, command record and width helpers for the W-channel downsizer.
package axi_dw_pkg;
   typedef enum logic {IDLE, SPLIT} state_e;
   typedef struct packed {
      logic [7:0] addr;
      logic [2:0] size;
      logic [7:0] len;
   } cmd_t;
   function automatic int unsigned off_bits(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction
   function automatic int unsigned num_beats(input logic [2:0] size, input int unsigned off_n);
      return (32'(size) > off_n) ? 32'd1 << (32'(size) - off_n) : 32'd1;
   endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: command queue exposing the head and the entry behind it; push while full is allowed with a pop.
module fifo_v3 #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [Width-1:0]             data_i,
   output logic [Width-1:0]             data_o,
   output logic [Width-1:0]             nxt_o,
   output logic [$clog2(Depth+1)-1:0]   cnt_o,
   output logic                         full_o,
   output logic                         empty_o
);
   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = $clog2(Depth + 1);
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      rd_nxt = inc(rd_q);
      data_o = mem_q[rd_q];
      nxt_o = mem_q[rd_nxt];
      cnt_o = cnt_q;
      full_o = cnt_q == CW'(Depth);
      empty_o = cnt_q == '0;
      do_pop = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      mem_d = mem_q;
      wr_d = do_push ? inc(wr_q) : wr_q;
      rd_d = do_pop ? rd_nxt : rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      if (do_push) mem_d[wr_q] = data_i;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         mem_q <= '{default: '0};
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/axi_w_dw_downsizer.sv
// axi_w_dw_downsizer: splits each wide W beat into narrow beats following the queued AW command.
module axi_w_dw_downsizer
   import axi_dw_pkg::*;
#(
   parameter int unsigned SlvDataWidth = 64,
   parameter int unsigned MstDataWidth = 32,
   parameter int unsigned UserWidth = 8,
   parameter int unsigned CmdDepth = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               cmd_valid_i,
   output logic                               cmd_ready_o,
   input  logic [$clog2(SlvDataWidth/8)-1:0]  cmd_addr_i,
   input  logic [2:0]                         cmd_size_i,
   input  logic [7:0]                         cmd_len_i,
   input  logic [SlvDataWidth-1:0]            slv_w_data_i,
   input  logic [SlvDataWidth/8-1:0]          slv_w_strb_i,
   input  logic [UserWidth-1:0]               slv_w_user_i,
   input  logic                               slv_w_last_i,
   input  logic                               slv_w_valid_i,
   output logic                               slv_w_ready_o,
   output logic [MstDataWidth-1:0]            mst_w_data_o,
   output logic [MstDataWidth/8-1:0]          mst_w_strb_o,
   output logic [UserWidth-1:0]               mst_w_user_o,
   output logic                               mst_w_last_o,
   output logic                               mst_w_valid_o,
   input  logic                               mst_w_ready_i,
   output logic                               last_err_o
);
   localparam int unsigned OffW = off_bits(SlvDataWidth);
   localparam int unsigned OffN = off_bits(MstDataWidth);
   localparam int unsigned RW = OffW - OffN;
   localparam int unsigned CW = $clog2(CmdDepth + 1);
   state_e state_q, state_d;
   cmd_t cmd_in, head, nxt, ccmd;
   logic [CW-1:0] cnt;
   logic full, empty, nfin, fin, pop, acc, is_last;
   logic [7:0] mask, baddr;
   logic [SlvDataWidth-1:0] data_q, data_d;
   logic [SlvDataWidth/8-1:0] strb_q, strb_d;
   logic [UserWidth-1:0] user_q, user_d;
   logic [7:0] addr_q, addr_d, naddr_q, naddr_d, beat_cnt_q, beat_cnt_d;
   logic [2:0] size_q, size_d;
   logic [RW:0] nar_cnt_q, nar_cnt_d;
   logic blast_q, blast_d, last_err_q, last_err_d;
   logic [RW-1:0] idx;
   fifo_v3 #(.Depth(CmdDepth), .Width($bits(cmd_t))) i_cmd_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(cmd_valid_i && cmd_ready_o), .pop_i(pop),
      .data_i(cmd_in), .data_o(head), .nxt_o(nxt), .cnt_o(cnt), .full_o(full), .empty_o(empty)
   );
   always_comb begin
      cmd_in = '{addr: 8'(cmd_addr_i), size: cmd_size_i, len: cmd_len_i};
      nfin = state_q == SPLIT && nar_cnt_q == (RW+1)'(num_beats(size_q, OffN) - 1);
      fin = nfin && mst_w_ready_i;
      pop = fin && blast_q;
      cmd_ready_o = !full || pop;
      // a beat accepted while the current command retires belongs to the next queued command
      slv_w_ready_o = (state_q == IDLE) ? !empty : fin && (!blast_q || cnt > CW'(1));
      acc = slv_w_valid_i && slv_w_ready_o;
      ccmd = (state_q == SPLIT && blast_q) ? nxt : head;
      mask = 8'((32'd1 << ccmd.size) - 1);
      baddr = (beat_cnt_q == '0) ? ccmd.addr & ~mask : naddr_q;
      is_last = beat_cnt_q == ccmd.len;
      state_d = state_q;
      data_d = data_q;
      strb_d = strb_q;
      user_d = user_q;
      addr_d = addr_q;
      naddr_d = naddr_q;
      beat_cnt_d = beat_cnt_q;
      size_d = size_q;
      nar_cnt_d = nar_cnt_q;
      blast_d = blast_q;
      last_err_d = 1'b0;
      if (acc) begin
         state_d = SPLIT;
         data_d = slv_w_data_i;
         strb_d = slv_w_strb_i;
         user_d = slv_w_user_i;
         addr_d = baddr;
         size_d = ccmd.size;
         blast_d = is_last;
         nar_cnt_d = '0;
         beat_cnt_d = is_last ? '0 : beat_cnt_q + 8'd1;
         naddr_d = (baddr + 8'(32'd1 << ccmd.size)) & 8'(SlvDataWidth / 8 - 1);
         last_err_d = slv_w_last_i != is_last;
      end else if (fin) begin
         state_d = IDLE;
         nar_cnt_d = '0;
      end else if (state_q == SPLIT && mst_w_ready_i) begin
         nar_cnt_d = nar_cnt_q + 1'b1;
      end
      idx = RW'(addr_q >> OffN) + RW'(nar_cnt_q);
      mst_w_data_o = data_q[idx*MstDataWidth +: MstDataWidth];
      mst_w_strb_o = strb_q[idx*(MstDataWidth/8) +: MstDataWidth/8];
      mst_w_user_o = user_q;
      mst_w_valid_o = state_q == SPLIT;
      mst_w_last_o = nfin && blast_q;
      last_err_o = last_err_q;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         data_q <= '0;
         strb_q <= '0;
         user_q <= '0;
         addr_q <= '0;
         naddr_q <= '0;
         beat_cnt_q <= '0;
         size_q <= '0;
         nar_cnt_q <= '0;
         blast_q <= 1'b0;
         last_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         strb_q <= strb_d;
         user_q <= user_d;
         addr_q <= addr_d;
         naddr_q <= naddr_d;
         beat_cnt_q <= beat_cnt_d;
         size_q <= size_d;
         nar_cnt_q <= nar_cnt_d;
         blast_q <= blast_d;
         last_err_q <= last_err_d;
      end
   end
endmodule

// File: tb/tb_axi_w_dw_downsizer.sv
// tb_axi_w_dw_downsizer: directed scenarios for the 64->32 W downsizer with hand-computed narrow beats.
module tb_axi_w_dw_downsizer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   logic cmd_valid_i = 1'b0, cmd_ready_o;
   logic [2:0] cmd_addr_i = '0, cmd_size_i = '0;
   logic [7:0] cmd_len_i = '0;
   logic [63:0] slv_w_data_i = '0;
   logic [7:0] slv_w_strb_i = '0, slv_w_user_i = '0;
   logic slv_w_last_i = 1'b0, slv_w_valid_i = 1'b0, slv_w_ready_o;
   logic [31:0] mst_w_data_o;
   logic [3:0] mst_w_strb_o;
   logic [7:0] mst_w_user_o;
   logic mst_w_last_o, mst_w_valid_o, last_err_o;
   logic mst_w_ready_i = 1'b1;
   int n_cmp = 0, n_err = 0, cyc = 0, err_cnt = 0;
   logic [31:0] q_data[$];
   logic [3:0] q_strb[$];
   logic [7:0] q_user[$];
   logic q_last[$];
   int q_cyc[$];

   axi_w_dw_downsizer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_size_i(cmd_size_i), .cmd_len_i(cmd_len_i),
      .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i), .slv_w_user_i(slv_w_user_i),
      .slv_w_last_i(slv_w_last_i), .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
      .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_user_o(mst_w_user_o),
      .mst_w_last_o(mst_w_last_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
      .last_err_o(last_err_o)
   );

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (mst_w_valid_o && mst_w_ready_i) begin
         q_data.push_back(mst_w_data_o);
         q_strb.push_back(mst_w_strb_o);
         q_user.push_back(mst_w_user_o);
         q_last.push_back(mst_w_last_o);
         q_cyc.push_back(cyc);
      end
      if (last_err_o) err_cnt++;
   end

   // all driver tasks start and end 1 time unit after a rising edge
   task automatic push_cmd(input logic [2:0] a, input logic [2:0] s, input logic [7:0] l);
      cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_size_i = s; cmd_len_i = l;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready_o) break;
         if (i == 99) begin n_cmp++; n_err++; $display("FAIL cmd_handshake timeout cmd_ready_o=%b want 1", cmd_ready_o); end
      end
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic [7:0] u, input logic l);
      slv_w_valid_i = 1'b1; slv_w_data_i = d; slv_w_strb_i = st; slv_w_user_i = u; slv_w_last_i = l;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (slv_w_ready_o) break;
         if (i == 99) begin n_cmp++; n_err++; $display("FAIL w_handshake timeout slv_w_ready_o=%b want 1", slv_w_ready_o); end
      end
      @(posedge clk); #1;
      slv_w_valid_i = 1'b0; slv_w_last_i = 1'b0;
   endtask

   task automatic wait_beats(input int base, input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q_data.size() >= base + n) break;
         if (i == 199) begin n_cmp++; n_err++; $display("FAIL beat_wait timeout got %0d beats want %0d", q_data.size() - base, n); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp += 6;
      if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_o); end
      if (slv_w_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_slv_ready got %b want 0", slv_w_ready_o); end
      if (mst_w_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mst_valid got %b want 0", mst_w_valid_o); end
      if (mst_w_last_o !== 1'b0) begin n_err++; $display("FAIL reset_mst_last got %b want 0", mst_w_last_o); end
      if (last_err_o !== 1'b0) begin n_err++; $display("FAIL reset_last_err got %b want 0", last_err_o); end
      if ({mst_w_data_o, mst_w_strb_o, mst_w_user_o} !== 44'h0) begin n_err++; $display("FAIL reset_payload got %h want 0", {mst_w_data_o, mst_w_strb_o, mst_w_user_o}); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [31:0] ed [4] = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
      logic [3:0] es [4] = '{4'hF, 4'h7, 4'h1, 4'hE};
      logic [7:0] eu [4] = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
      logic el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int base = q_data.size();
      mst_w_ready_i = 1'b1;
      push_cmd(3'd0, 3'd3, 8'd1);
      send_w(64'h1111_2222_3333_4444, 8'h7F, 8'h5A, 1'b0);
      send_w(64'h5555_6666_7777_8888, 8'hE1, 8'hA5, 1'b1);
      wait_beats(base, 4);
      for (int k = 0; k < 4; k++) begin
         n_cmp += 4;
         if (q_data[base+k] !== ed[k]) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", k, q_data[base+k], ed[k]); end
         if (q_strb[base+k] !== es[k]) begin n_err++; $display("FAIL basic_strb[%0d] got %h want %h", k, q_strb[base+k], es[k]); end
         if (q_user[base+k] !== eu[k]) begin n_err++; $display("FAIL basic_user[%0d] got %h want %h", k, q_user[base+k], eu[k]); end
         if (q_last[base+k] !== el[k]) begin n_err++; $display("FAIL basic_last[%0d] got %b want %b", k, q_last[base+k], el[k]); end
      end
   endtask

   task automatic test_unaligned();
      logic [31:0] ed [3] = '{32'hAAAA_0001, 32'hDDDD_0004, 32'hEEEE_0005};
      logic [3:0] es [3] = '{4'h3, 4'hC, 4'hA};
      logic el [3] = '{1'b0, 1'b0, 1'b1};
      int base = q_data.size();
      push_cmd(3'd4, 3'd2, 8'd2);
      send_w(64'hAAAA_0001_BBBB_0002, 8'h30, 8'h11, 1'b0);
      send_w(64'hCCCC_0003_DDDD_0004, 8'h0C, 8'h22, 1'b0);
      send_w(64'hEEEE_0005_FFFF_0006, 8'hA0, 8'h33, 1'b1);
      wait_beats(base, 3);
      for (int k = 0; k < 3; k++) begin
         n_cmp += 3;
         if (q_data[base+k] !== ed[k]) begin n_err++; $display("FAIL unal_data[%0d] got %h want %h", k, q_data[base+k], ed[k]); end
         if (q_strb[base+k] !== es[k]) begin n_err++; $display("FAIL unal_strb[%0d] got %h want %h", k, q_strb[base+k], es[k]); end
         if (q_last[base+k] !== el[k]) begin n_err++; $display("FAIL unal_last[%0d] got %b want %b", k, q_last[base+k], el[k]); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] ed [4] = '{32'h89AB_CDEF, 32'h0123_4567, 32'h7654_3210, 32'hFEDC_BA98};
      int base = q_data.size();
      mst_w_ready_i = 1'b0;
      push_cmd(3'd0, 3'd3, 8'd1);
      send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 8'h07, 1'b0);
      @(negedge clk);
      n_cmp += 2;
      if (mst_w_valid_o !== 1'b1) begin n_err++; $display("FAIL latency_valid got %b want 1", mst_w_valid_o); end
      if (mst_w_data_o !== 32'h89AB_CDEF) begin n_err++; $display("FAIL latency_data got %h want 89abcdef", mst_w_data_o); end
      @(posedge clk); #1;
      mst_w_ready_i = 1'b1;
      @(posedge clk); #1;
      mst_w_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp += 4;
         if (mst_w_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", c, mst_w_valid_o); end
         if (mst_w_data_o !== 32'h0123_4567) begin n_err++; $display("FAIL stall_data[%0d] got %h want 01234567", c, mst_w_data_o); end
         if (mst_w_last_o !== 1'b0) begin n_err++; $display("FAIL stall_last[%0d] got %b want 0", c, mst_w_last_o); end
         if (slv_w_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_slv_ready[%0d] got %b want 0", c, slv_w_ready_o); end
      end
      @(posedge clk); #1;
      mst_w_ready_i = 1'b1;
      send_w(64'hFEDC_BA98_7654_3210, 8'hFF, 8'h07, 1'b1);
      wait_beats(base, 4);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (q_data.size() - base !== 4) begin n_err++; $display("FAIL stall_count got %0d want 4", q_data.size() - base); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (q_data[base+k] !== ed[k]) begin n_err++; $display("FAIL stall_seq[%0d] got %h want %h", k, q_data[base+k], ed[k]); end
      end
   endtask

   task automatic test_back_to_back();
      int base = q_data.size();
      mst_w_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_cmd(3'd0, 3'd3, 8'd0);
         n_cmp++;
         if (cmd_ready_o !== (i < 3)) begin n_err++; $display("FAIL b2b_cmd_ready[%0d] got %b want %b", i, cmd_ready_o, i < 3); end
      end
      for (int k = 0; k < 4; k++)
         send_w({32'hB000_0001 + 32'(2*k), 32'hB000_0000 + 32'(2*k)}, 8'hFF, 8'h00, 1'b1);
      wait_beats(base, 8);
      for (int j = 0; j < 8; j++) begin
         n_cmp += 2;
         if (q_data[base+j] !== 32'hB000_0000 + 32'(j)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", j, q_data[base+j], 32'hB000_0000 + 32'(j)); end
         if (q_last[base+j] !== 1'(j % 2)) begin n_err++; $display("FAIL b2b_last[%0d] got %b want %b", j, q_last[base+j], j % 2); end
         if (j > 0) begin
            n_cmp++;
            if (q_cyc[base+j] - q_cyc[base+j-1] !== 1) begin n_err++; $display("FAIL b2b_gap[%0d] got %0d want 1", j, q_cyc[base+j] - q_cyc[base+j-1]); end
         end
      end
      n_cmp++;
      if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_drained_ready got %b want 1", cmd_ready_o); end
   endtask

   task automatic test_last_err();
      logic el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int base = q_data.size();
      int e0 = err_cnt;
      push_cmd(3'd0, 3'd3, 8'd1);
      send_w(64'h2222_2222_1111_1111, 8'hFF, 8'h00, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (last_err_o !== 1'b1) begin n_err++; $display("FAIL lasterr_pulse got %b want 1", last_err_o); end
      @(posedge clk); #1;
      send_w(64'h4444_4444_3333_3333, 8'hFF, 8'h00, 1'b1);
      wait_beats(base, 4);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL lasterr_count got %0d want 1", err_cnt - e0); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (q_last[base+k] !== el[k]) begin n_err++; $display("FAIL lasterr_last[%0d] got %b want %b", k, q_last[base+k], el[k]); end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      mst_w_ready_i = 1'b0;
      push_cmd(3'd0, 3'd3, 8'd1);
      send_w(64'h9999_9999_8888_8888, 8'hFF, 8'h44, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp += 6;
      if (mst_w_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", mst_w_valid_o); end
      if (mst_w_last_o !== 1'b0) begin n_err++; $display("FAIL rstmid_last got %b want 0", mst_w_last_o); end
      if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_cmd_ready got %b want 1", cmd_ready_o); end
      if (slv_w_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_slv_ready got %b want 0", slv_w_ready_o); end
      if (last_err_o !== 1'b0) begin n_err++; $display("FAIL rstmid_last_err got %b want 0", last_err_o); end
      if ({mst_w_data_o, mst_w_strb_o, mst_w_user_o} !== 44'h0) begin n_err++; $display("FAIL rstmid_payload got %h want 0", {mst_w_data_o, mst_w_strb_o, mst_w_user_o}); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      mst_w_ready_i = 1'b1;
      base = q_data.size();
      push_cmd(3'd4, 3'd2, 8'd0);
      send_w(64'hCAFE_BABE_0BAD_F00D, 8'hF0, 8'h3C, 1'b1);
      wait_beats(base, 1);
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 5;
      if (q_data.size() - base !== 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", q_data.size() - base); end
      if (q_data[base] !== 32'hCAFE_BABE) begin n_err++; $display("FAIL rstmid_data got %h want cafebabe", q_data[base]); end
      if (q_strb[base] !== 4'hF) begin n_err++; $display("FAIL rstmid_strb got %h want f", q_strb[base]); end
      if (q_user[base] !== 8'h3C) begin n_err++; $display("FAIL rstmid_user got %h want 3c", q_user[base]); end
      if (q_last[base] !== 1'b1) begin n_err++; $display("FAIL rstmid_lastflag got %b want 1", q_last[base]); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_unaligned();
      test_stall();
      test_back_to_back();
      test_last_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d want completion", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axi_w_dw_downsizer.md
AXI_W_DW_DOWNSIZER -- requirements
Module: axi_w_dw_downsizer

Interface
REQ-001 SHALL have parameter SlvDataWidth, default 64: wide (slave-port) W data width in bits; power of 2, at least 16.
REQ-002 SHALL have parameter MstDataWidth, default 32: narrow (master-port) W data width; power of 2, at least 8; Ratio = SlvDataWidth/MstDataWidth is 2..16.
REQ-003 SHALL have parameter UserWidth, default 8: W user width.
REQ-004 SHALL have parameter CmdDepth, default 4: command FIFO depth, at least 2.
REQ-005 clk  in  1  clock; all state is updated on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-high.
REQ-007 cmd_valid_i / cmd_ready_o  in/out  1  command handshake, one command per slave-side AW.
REQ-008 cmd_addr_i  in  log2(SlvDataWidth/8)  AW address low bits.
REQ-009 cmd_size_i  in  3  AW size, at most log2(SlvDataWidth/8); cmd_len_i  in  8  AW len, counted in wide beats minus 1; burst type is INCR.
REQ-010 slv_w_data_i/strb_i/user_i/last_i/valid_i  in  SlvDataWidth/SlvDataWidth/8/UserWidth/1/1  wide W beat; slv_w_ready_o  out  1.
REQ-011 mst_w_data_o/strb_o/user_o/last_o/valid_o  out  MstDataWidth/MstDataWidth/8/UserWidth/1/1  narrow W beat; mst_w_ready_i  in  1.
REQ-012 last_err_o  out  1  one-cycle pulse when slv_w_last_i disagrees with the command's len.

Function
REQ-013 Commands SHALL be queued in a CmdDepth-entry FIFO; cmd_ready_o=0 when the FIFO is full; push and pop in the same cycle SHALL be allowed when full.
REQ-014 Each wide beat SHALL be split into N = max(1, 2^(size-log2(MstDataWidth/8))) narrow beats.
REQ-015 Narrow beat k SHALL carry slice index = cur_addr[log2(SlvDataWidth/8)-1:log2(MstDataWidth/8)] + k, modulo Ratio, for data and strb; user SHALL be copied unchanged.
REQ-016 cur_addr SHALL start at cmd_addr aligned down to 2^size and advance by 2^size per wide beat, wrapping within the wide word.
REQ-017 FSM states: IDLE (no command, or buffer empty) and SPLIT (buffer holds a wide beat, emitting narrow beats).
REQ-018 IDLE->SPLIT SHALL occur on slv_w handshake while the FIFO is non-empty; slv_w_ready_o=0 while the FIFO is empty.
REQ-019 SPLIT->IDLE SHALL occur on the handshake of the final narrow beat unless a new wide beat is accepted in the same cycle, in which case the FSM stays in SPLIT.
REQ-020 slv_w_ready_o SHALL be high when the buffer is empty, or when the final narrow beat handshakes this cycle and a command remains for the next beat.
REQ-021 Latency: a wide beat accepted at edge N SHALL present its first narrow beat at cycle N+1; sustained throughput SHALL be one narrow beat per cycle.
REQ-022 mst_w_valid_o SHALL be 1 in SPLIT; the narrow beat SHALL hold stable while mst_w_ready_i=0.
REQ-023 mst_w_last_o SHALL be 1 only on the final narrow beat of the final wide beat (wide-beat count = cmd_len); the command SHALL pop on that handshake.
REQ-024 If slv_w_last_i differs from (wide-beat count == cmd_len), last_err_o SHALL pulse in the cycle after acceptance; splitting SHALL follow cmd_len, not slv_w_last_i.
REQ-025 Counters: wide-beat counter 8 bits, narrow counter log2(Ratio)+1 bits; no overflow is possible for legal inputs.

Reset
REQ-026 While rst_n=1: FIFO SHALL be empty, FSM in IDLE, counters 0, buffer invalid; in-flight beats are discarded.
REQ-027 Reset values: cmd_ready_o=1, slv_w_ready_o=0, mst_w_valid_o=0, mst_w_last_o=0, last_err_o=0, data/strb/user=0.

Structure
REQ-028 Beat struct typedefs and width-derivation functions (offset bits, N) SHALL reside in a shared package, axi_dw_pkg.
REQ-029 The command FIFO SHALL be a single sub-module instance, fifo_v3.

Verification
REQ-030 64->32, cmd addr=0 size=3 len=1, two wide beats D0,D1 -> four narrow beats D0[31:0], D0[63:32], D1[31:0], D1[63:32]; last only on the 4th.
REQ-031 cmd addr=4 size=2 len=2 -> three narrow beats with slices 1, 0, 1; last on the 3rd.
REQ-032 mst_w_ready_i low for 3 cycles mid-burst -> outputs held stable, no beat lost or duplicated, slv_w_ready_o=0.
REQ-033 Four commands queued back-to-back with mst_w_ready_i=1 -> cmd_ready_o falls after the 4th push; narrow beats issue every cycle with no bubble between bursts.
REQ-034 len=1 with slv_w_last_i=1 on the first wide beat -> last_err_o pulses once; mst_w_last_o is still on the 4th narrow beat.
REQ-035 rst_n asserted mid-burst -> next cycle all outputs are at reset values; a fresh command then completes correctly.
